// File: rtl/viterbi_dec.sv
// rtl/viterbi_dec.sv - hard-decision K=3 rate-1/2 (7,5) Viterbi decoder, per-frame traceback
module viterbi_dec #(
  parameter int FRAME_LEN = 64,
  parameter int PM_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic y0,
  input  logic y1,
  output logic in_ready,
  output logic out_valid,
  output logic bit_out,
  output logic frame_done
);

  localparam int            CW         = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] T_LAST     = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] T_OUT_LAST = CW'(FRAME_LEN - 3);
  localparam logic [PM_W-1:0] PM_INIT  = PM_W'((1 << (PM_W - 2)) - 1);

  typedef enum logic [1:0] {ST_ACS, ST_TRACE, ST_OUT} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       t;
  logic [PM_W-1:0]     pm     [4];
  logic [PM_W-1:0]     pm_nxt [4];
  logic [PM_W:0]       cand0  [4];
  logic [PM_W:0]       cand1  [4];
  logic [PM_W:0]       surv_m [4];
  logic [PM_W:0]       min01, min23, min_all;
  logic [3:0]          dec_nxt;
  logic [3:0]          surv [FRAME_LEN];
  logic [FRAME_LEN-1:0] dbuf;
  logic [1:0]          tr_s;
  logic                accept;

  function automatic logic [1:0] branch_metric(input logic b, input logic [1:0] p,
                                               input logic r0, input logic r1);
    return {1'b0, b ^ p[1] ^ p[0] ^ r0} + {1'b0, b ^ p[0] ^ r1};
  endfunction

  assign accept = in_valid && (state == ST_ACS);

  // State s is reached from {s[0],0} or {s[0],1} with input bit s[1]; ties keep {s[0],0}.
  for (genvar s = 0; s < 4; s++) begin : g_acs
    localparam logic [1:0] P0 = 2'(2 * (s % 2));
    localparam logic [1:0] P1 = 2'(2 * (s % 2) + 1);
    localparam logic       B  = 1'(s / 2);
    assign cand0[s]   = {1'b0, pm[P0]} + {{(PM_W-1){1'b0}}, branch_metric(B, P0, y0, y1)};
    assign cand1[s]   = {1'b0, pm[P1]} + {{(PM_W-1){1'b0}}, branch_metric(B, P1, y0, y1)};
    assign dec_nxt[s] = cand1[s] < cand0[s];
    assign surv_m[s]  = dec_nxt[s] ? cand1[s] : cand0[s];
    assign pm_nxt[s]  = PM_W'(surv_m[s] - min_all);
  end

  assign min01   = (surv_m[0] < surv_m[1]) ? surv_m[0] : surv_m[1];
  assign min23   = (surv_m[2] < surv_m[3]) ? surv_m[2] : surv_m[3];
  assign min_all = (min01 < min23) ? min01 : min23;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACS;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACS:   if (accept && t == T_LAST) state_nxt = ST_TRACE;
      ST_TRACE: if (t == '0) state_nxt = ST_OUT;
      ST_OUT:   if (t == T_OUT_LAST) state_nxt = ST_ACS;
      default:  state_nxt = ST_ACS;
    endcase
  end

  // One counter serves all phases: up during ACS, down during TRACE, up again during OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t     <= '0;
      tr_s  <= '0;
      pm[0] <= '0;
      pm[1] <= PM_INIT;
      pm[2] <= PM_INIT;
      pm[3] <= PM_INIT;
    end else begin
      case (state)
        ST_ACS: begin
          tr_s <= '0;
          if (accept) begin
            pm <= pm_nxt;
            if (t != T_LAST) t <= t + 1'b1;
          end
        end
        ST_TRACE: begin
          tr_s <= {tr_s[0], surv[t][tr_s]};
          if (t != '0) t <= t - 1'b1;
        end
        ST_OUT: begin
          if (t == T_OUT_LAST) begin
            t     <= '0;
            pm[0] <= '0;
            pm[1] <= PM_INIT;
            pm[2] <= PM_INIT;
            pm[3] <= PM_INIT;
          end else begin
            t <= t + 1'b1;
          end
        end
        default: t <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) surv[t] <= dec_nxt;
    if (state == ST_TRACE) dbuf[t] <= tr_s[1];
  end

  assign in_ready   = (state == ST_ACS);
  assign out_valid  = (state == ST_OUT);
  assign bit_out    = out_valid & dbuf[t];
  assign frame_done = out_valid && (t == T_OUT_LAST);

endmodule

// File: tb/tb_viterbi_dec.sv
// tb/tb_viterbi_dec.sv - self-checking bench for viterbi_dec (short and long frame instances)
module tb_viterbi_dec;

  localparam int LEN_S = 6;
  localparam int LEN_L = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic iv [2];
  logic y0s [2];
  logic y1s [2];
  logic rdy [2];
  logic ov [2];
  logic bo [2];
  logic fd [2];

  int n_chk = 0;
  int n_fail = 0;

  logic [1:0] tx[$];
  bit         exp_q[$];

  typedef struct packed {
    logic [0:5][1:0] pairs;
    logic [0:3]      data;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  viterbi_dec #(.FRAME_LEN(LEN_S), .PM_W(8)) u_short (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .y0(y0s[0]), .y1(y1s[0]),
    .in_ready(rdy[0]), .out_valid(ov[0]), .bit_out(bo[0]), .frame_done(fd[0])
  );

  viterbi_dec #(.FRAME_LEN(LEN_L), .PM_W(8)) u_long (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .y0(y0s[1]), .y1(y1s[1]),
    .in_ready(rdy[1]), .out_valid(ov[1]), .bit_out(bo[1]), .frame_done(fd[1])
  );

  function automatic int flen(input int k);
    return (k == 0) ? LEN_S : LEN_L;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference encoder: shift register of the two previous data bits, generators 7 and 5.
  task automatic build_frame(input int k, input bit with_err);
    int  len;
    bit  d1, d0, b;
    int  p;
    len = flen(k);
    tx.delete();
    exp_q.delete();
    d1 = 0;
    d0 = 0;
    for (int i = 0; i < len; i++) begin
      b = (i < len - 2) ? 1'($urandom) : 1'b0;
      if (i < len - 2) exp_q.push_back(b);
      tx.push_back({b ^ d1 ^ d0, b ^ d0});
      d0 = d1;
      d1 = b;
    end
    if (with_err) begin
      p = $urandom_range(0, len - 1);
      tx[p] = tx[p] ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
    end
  endtask

  // Entered and left at a falling edge; drives tx, collects decoded bits, checks timing.
  task automatic run_frame(input int k, input string tag, input bit gaps, input bit flood);
    int         len, idx, low, first_out, n_fd, done_at, budget;
    bit         acc_done, finished, proto_err;
    bit         got[$];
    logic [63:0] gv, ev;
    len = flen(k);
    idx = 0; low = 0; first_out = -1; n_fd = 0; done_at = -1;
    budget = 4 * len + 400;
    acc_done = 0; finished = 0; proto_err = 0;
    while (!finished && budget > 0) begin
      if (acc_done) begin
        if (rdy[k]) begin
          finished = 1;
        end else begin
          low++;
          if (ov[k]) begin
            if (first_out < 0) first_out = low;
            got.push_back(bo[k]);
            if (fd[k]) begin
              n_fd++;
              done_at = got.size();
            end
          end else begin
            if (got.size() > 0) proto_err = 1;
            if (fd[k]) proto_err = 1;
          end
        end
      end
      if (!finished) begin
        if (!acc_done) begin
          if (gaps && $urandom_range(0, 3) == 0) begin
            iv[k] = 1'b0;
          end else begin
            iv[k]  = 1'b1;
            y0s[k] = tx[idx][1];
            y1s[k] = tx[idx][0];
            if (rdy[k]) begin
              idx++;
              if (idx == tx.size()) acc_done = 1;
            end
          end
        end else if (flood) begin
          iv[k]  = 1'b1;
          y0s[k] = 1'($urandom);
          y1s[k] = 1'($urandom);
        end else begin
          iv[k] = 1'b0;
        end
        @(negedge clk);
        budget--;
      end
    end
    iv[k] = 1'b0;
    check({tag, " completed"}, 64'(finished), 64'd1);
    gv = '0;
    ev = '0;
    for (int i = 0; i < got.size() && i < 64; i++) gv[i] = got[i];
    for (int i = 0; i < exp_q.size(); i++) ev[i] = exp_q[i];
    check({tag, " in_ready low cycles"}, 64'(low), 64'(2 * len - 2));
    check({tag, " first out latency"}, 64'(first_out), 64'(len + 1));
    check({tag, " bit count"}, 64'(got.size()), 64'(len - 2));
    check({tag, " bits"}, gv, ev);
    check({tag, " frame_done count"}, 64'(n_fd), 64'd1);
    check({tag, " frame_done position"}, 64'(done_at), 64'(len - 2));
    check({tag, " contiguous output"}, 64'(proto_err), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_ov;
    int wait_cnt;
    vecs[0] = '{pairs: {2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11}, data: 4'b1011};
    vecs[1] = '{pairs: {2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 2'b11}, data: 4'b1011};
    vecs[2] = '{pairs: {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, data: 4'b0000};
    vecs[3] = '{pairs: {2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11}, data: 4'b1111};
    vecs[4] = '{pairs: {2'b00, 2'b11, 2'b01, 2'b01, 2'b11, 2'b00}, data: 4'b0110};
    vecs[5] = '{pairs: {2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b11}, data: 4'b0001};

    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; y0s[k] = 1'b0; y1s[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset out_valid[%0d]", k), 64'(ov[k]), 64'd0);
      check($sformatf("reset bit_out[%0d]", k), 64'(bo[k]), 64'd0);
      check($sformatf("reset frame_done[%0d]", k), 64'(fd[k]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset in_ready short", 64'(rdy[0]), 64'd1);
    check("post-reset in_ready long", 64'(rdy[1]), 64'd1);

    for (int i = 0; i < 6; i++) begin
      tx.delete();
      exp_q.delete();
      for (int j = 0; j < 6; j++) tx.push_back(vecs[i].pairs[j]);
      for (int j = 0; j < 4; j++) exp_q.push_back(vecs[i].data[j]);
      run_frame(0, $sformatf("vec%0d", i), 1'b0, 1'b0);
    end

    for (int f = 0; f < 20; f++) begin
      build_frame(0, 1'b0);
      run_frame(0, $sformatf("short rand %0d", f), 1'b1, 1'b0);
    end

    build_frame(1, 1'b0);
    run_frame(1, "long clean", 1'b0, 1'b0);

    build_frame(1, 1'b0);
    run_frame(1, "long flood", 1'b0, 1'b1);
    build_frame(1, 1'b0);
    run_frame(1, "after flood", 1'b1, 1'b0);

    // Abort a frame with reset while it is emitting bits.
    build_frame(1, 1'b0);
    for (int i = 0; i < tx.size(); i++) begin
      iv[1] = 1'b1; y0s[1] = tx[i][1]; y1s[1] = tx[i][0];
      @(negedge clk);
    end
    iv[1] = 1'b0;
    wait_cnt = 0;
    while (!ov[1] && wait_cnt < 300) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("abort reached OUT", 64'(ov[1]), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 64'(ov[1]), 64'd0);
    check("abort frame_done", 64'(fd[1]), 64'd0);
    check("abort in_ready", 64'(rdy[1]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    n_ov = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (ov[1]) n_ov++;
      if (!rdy[1]) n_ov++;
    end
    check("abort no partial output", 64'(n_ov), 64'd0);
    build_frame(1, 1'b0);
    run_frame(1, "after abort", 1'b0, 1'b0);

    for (int f = 0; f < 100; f++) begin
      build_frame(1, 1'b1);
      run_frame(1, $sformatf("err frame %0d", f), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
